// File: rtl/controlador_hierarquia.sv
// Request sequencer for the L1/L2/main-memory hierarchy datapath: round-robin between
// fetch (port 0) and load/store (port 1). Define HIER_STATS_EN to add hit/miss/writeback counters.
module controlador_hierarquia #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] dp_address,
  output logic [DATA_W-1:0] dp_wdata,
  output logic              dp_write,
  output logic              dp_l1_lookup,
  output logic              dp_l2_lookup,
  output logic              dp_writeback,
  output logic              dp_mem_read,
  output logic              dp_fill,
`ifdef HIER_STATS_EN
  output logic [15:0]       stat_l1_hit,
  output logic [15:0]       stat_l2_hit,
  output logic [15:0]       stat_miss,
  output logic [15:0]       stat_wb,
`endif
  input  logic              hit_L1,
  input  logic              hit_L2,
  input  logic              l2_victim_dirty,
  input  logic [DATA_W-1:0] dp_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE, L1_LOOK, L2_LOOK, WB, MEM, FILL, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rr_last_q;
  logic                grant_idx;
  logic                grant_en;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                write_q;
  logic                id_q;
  logic [DATA_W-1:0]   rdata_q;

  // On a tie the port that did not win last time gets the grant.
  assign grant_idx = (req_valid == 2'b11) ? ~rr_last_q : req_valid[1];
  // Gated by reset so no accept pulse leaks out while reset is held with requests pending.
  assign grant_en  = (state_q == IDLE) && (|req_valid) && reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_valid) state_d = L1_LOOK;
      L1_LOOK: state_d = hit_L1 ? DONE : L2_LOOK;
      L2_LOOK: begin
        if (hit_L2)               state_d = FILL;
        else if (l2_victim_dirty) state_d = WB;
        else                      state_d = MEM;
      end
      WB:      if (cnt_q == '0) state_d = MEM;
      MEM:     if (cnt_q == '0) state_d = FILL;
      FILL:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reload on every state change so WB->MEM starts a fresh MEM_LAT window.
  always_comb begin
    cnt_d = '0;
    if (state_d != state_q)
      cnt_d = CNT_W'(MEM_LAT - 1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    req_ready    = 2'b00;
    dp_l1_lookup = 1'b0;
    dp_l2_lookup = 1'b0;
    dp_writeback = 1'b0;
    dp_mem_read  = 1'b0;
    dp_fill      = 1'b0;
    resp_valid   = 1'b0;
    if (grant_en) req_ready = grant_idx ? 2'b10 : 2'b01;
    case (state_q)
      L1_LOOK: dp_l1_lookup = 1'b1;
      L2_LOOK: dp_l2_lookup = 1'b1;
      WB:      dp_writeback = 1'b1;
      MEM:     dp_mem_read  = 1'b1;
      FILL:    dp_fill      = 1'b1;
      DONE:    resp_valid   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_last_q <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      id_q      <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (grant_en) begin
        rr_last_q <= grant_idx;
        id_q      <= grant_idx;
        addr_q    <= grant_idx ? req_addr1 : req_addr0;
        wdata_q   <= grant_idx ? req_wdata1 : req_wdata0;
        write_q   <= req_write[grant_idx];
      end
      if ((state_q == L1_LOOK && hit_L1) || state_q == FILL)
        rdata_q <= dp_rdata;
    end
  end

  assign dp_address = addr_q;
  assign dp_wdata   = wdata_q;
  assign dp_write   = write_q;
  assign resp_id    = id_q;
  assign resp_rdata = rdata_q;

`ifdef HIER_STATS_EN
  logic [15:0] l1_hit_q, l2_hit_q, miss_q, wb_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      l1_hit_q <= '0;
      l2_hit_q <= '0;
      miss_q   <= '0;
      wb_q     <= '0;
    end else begin
      if (state_q == L1_LOOK && hit_L1 && l1_hit_q != 16'hFFFF)
        l1_hit_q <= l1_hit_q + 16'd1;
      if (state_q == L2_LOOK && hit_L2 && l2_hit_q != 16'hFFFF)
        l2_hit_q <= l2_hit_q + 16'd1;
      if (state_q == L2_LOOK && !hit_L2 && miss_q != 16'hFFFF)
        miss_q <= miss_q + 16'd1;
      if (state_q == WB && cnt_q == '0 && wb_q != 16'hFFFF)
        wb_q <= wb_q + 16'd1;
    end
  end

  assign stat_l1_hit = l1_hit_q;
  assign stat_l2_hit = l2_hit_q;
  assign stat_miss   = miss_q;
  assign stat_wb     = wb_q;
`endif

endmodule

// File: tb/tb_controlador_hierarquia.sv
// Directed bench for controlador_hierarquia; the datapath stub returns the latched address as data.
module tb_controlador_hierarquia;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        req_valid = 2'b00;
  logic [1:0]        req_write = 2'b00;
  logic [ADDR_W-1:0] req_addr0 = '0;
  logic [ADDR_W-1:0] req_addr1 = '0;
  logic [DATA_W-1:0] req_wdata0 = '0;
  logic [DATA_W-1:0] req_wdata1 = '0;
  logic [1:0]        req_ready;
  logic              resp_valid;
  logic              resp_id;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] dp_address;
  logic [DATA_W-1:0] dp_wdata;
  logic              dp_write;
  logic              dp_l1_lookup, dp_l2_lookup, dp_writeback, dp_mem_read, dp_fill;
  logic              hit_L1 = 1'b0;
  logic              hit_L2 = 1'b0;
  logic              l2_victim_dirty = 1'b0;
  logic [DATA_W-1:0] dp_rdata;
`ifdef HIER_STATS_EN
  logic [15:0]       stat_l1_hit, stat_l2_hit, stat_miss, stat_wb;
`endif

  int compared = 0;
  int mismatched = 0;

  assign dp_rdata = {{(DATA_W-ADDR_W){1'b0}}, dp_address};

  always #5 clock = ~clock;

  controlador_hierarquia dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id), .resp_rdata(resp_rdata),
    .dp_address(dp_address), .dp_wdata(dp_wdata), .dp_write(dp_write),
    .dp_l1_lookup(dp_l1_lookup), .dp_l2_lookup(dp_l2_lookup), .dp_writeback(dp_writeback),
    .dp_mem_read(dp_mem_read), .dp_fill(dp_fill),
`ifdef HIER_STATS_EN
    .stat_l1_hit(stat_l1_hit), .stat_l2_hit(stat_l2_hit), .stat_miss(stat_miss), .stat_wb(stat_wb),
`endif
    .hit_L1(hit_L1), .hit_L2(hit_L2), .l2_victim_dirty(l2_victim_dirty), .dp_rdata(dp_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for an accept pulse, checks it, then drops the granted request after the edge.
  task automatic applyStimulus(input string tag, input logic [1:0] expReady, input int expWait);
    int waited = 0;
    logic [1:0] got;
    #1;
    while (req_ready == 2'b00 && waited < 20) begin
      @(negedge clock);
      #1;
      waited++;
    end
    got = req_ready;
    checkOutput({tag, "_ready"}, {30'd0, got}, {30'd0, expReady});
    checkOutput({tag, "_wait"}, waited, expWait);
    @(posedge clock);
    #1;
    req_valid = req_valid & ~got;
  endtask

  task automatic waitResp(input string tag, input int expLat, input logic expId,
                          input logic [DATA_W-1:0] expData, input int expMem,
                          input int expWb, input int expL2);
    int lat = 0, nMem = 0, nWb = 0, nL2 = 0, overlap = 0;
    bit seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clock);
      lat++;
      nMem += int'(dp_mem_read);
      nWb  += int'(dp_writeback);
      nL2  += int'(dp_l2_lookup);
      if ($countones({dp_l1_lookup, dp_l2_lookup, dp_writeback, dp_mem_read, dp_fill}) > 1)
        overlap++;
      if (resp_valid) seen = 1;
    end
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_id"}, {31'd0, resp_id}, {31'd0, expId});
    checkOutput({tag, "_rdata"}, {16'd0, resp_rdata}, {16'd0, expData});
    checkOutput({tag, "_memcyc"}, nMem, expMem);
    checkOutput({tag, "_wbcyc"}, nWb, expWb);
    checkOutput({tag, "_l2cyc"}, nL2, expL2);
    checkOutput({tag, "_overlap"}, overlap, 0);
  endtask

  initial begin
    int found;
    int sawResp;
    #1;
    checkOutput("rst_ready", {30'd0, req_ready}, 0);
    checkOutput("rst_resp", {31'd0, resp_valid}, 0);
    checkOutput("rst_addr", {26'd0, dp_address}, 0);
    checkOutput("rst_strobes", {27'd0, dp_l1_lookup, dp_l2_lookup, dp_writeback, dp_mem_read, dp_fill}, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Clean miss on port 0
    @(negedge clock);
    req_addr0 = 6'd1; req_valid = 2'b01;
    applyStimulus("cleanmiss", 2'b01, 0);
    waitResp("cleanmiss", 7, 1'b0, 16'd1, 3, 0, 1);

    // L1 hit on port 0
    @(negedge clock);
    hit_L1 = 1'b1;
    req_valid = 2'b01;
    applyStimulus("l1hit", 2'b01, 0);
    waitResp("l1hit", 2, 1'b0, 16'd1, 0, 0, 0);

    // L2 hit on port 1
    @(negedge clock);
    hit_L1 = 1'b0; hit_L2 = 1'b1;
    req_addr1 = 6'd7; req_valid = 2'b10;
    applyStimulus("l2hit", 2'b10, 0);
    waitResp("l2hit", 4, 1'b1, 16'd7, 0, 0, 1);

    // Tie after a port-1 grant: port 0 first, port 1 in the cycle after DONE
    @(negedge clock);
    hit_L1 = 1'b1; hit_L2 = 1'b0;
    req_addr0 = 6'd5; req_addr1 = 6'd9; req_valid = 2'b11;
    applyStimulus("tie1a", 2'b01, 0);
    waitResp("tie1a", 2, 1'b0, 16'd5, 0, 0, 0);
    applyStimulus("tie1b", 2'b10, 1);
    waitResp("tie1b", 2, 1'b1, 16'd9, 0, 0, 0);

    // Second tie alternates back to port 0
    @(negedge clock);
    req_valid = 2'b11;
    applyStimulus("tie2a", 2'b01, 0);
    waitResp("tie2a", 2, 1'b0, 16'd5, 0, 0, 0);
    applyStimulus("tie2b", 2'b10, 1);
    waitResp("tie2b", 2, 1'b1, 16'd9, 0, 0, 0);

    // Write L1 hit on port 1: latched write data, old word returned
    @(negedge clock);
    req_addr1 = 6'd12; req_wdata1 = 16'hABCD; req_write = 2'b10; req_valid = 2'b10;
    applyStimulus("write", 2'b10, 0);
    checkOutput("write_flag", {31'd0, dp_write}, 1);
    checkOutput("write_wdata", {16'd0, dp_wdata}, 32'hABCD);
    checkOutput("write_addr", {26'd0, dp_address}, 12);
    waitResp("write", 2, 1'b1, 16'd12, 0, 0, 0);
    req_write = 2'b00;

    // Dirty miss on port 0
    @(negedge clock);
    hit_L1 = 1'b0; l2_victim_dirty = 1'b1;
    req_addr0 = 6'd20; req_valid = 2'b01;
    applyStimulus("dirty", 2'b01, 0);
    waitResp("dirty", 10, 1'b0, 16'd20, 3, 3, 1);
    l2_victim_dirty = 1'b0;

`ifdef HIER_STATS_EN
    @(negedge clock);
    checkOutput("stat_l1", {16'd0, stat_l1_hit}, 6);
    checkOutput("stat_l2", {16'd0, stat_l2_hit}, 1);
    checkOutput("stat_miss", {16'd0, stat_miss}, 2);
    checkOutput("stat_wb", {16'd0, stat_wb}, 1);
`endif

    // Reset during MEM aborts the transaction
    @(negedge clock);
    req_addr1 = 6'd3; req_valid = 2'b10;
    applyStimulus("abort", 2'b10, 0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clock);
      if (dp_mem_read) found = 1;
    end
    checkOutput("abort_reach_mem", found, 1);
    req_valid = 2'b10;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_memread", {31'd0, dp_mem_read}, 0);
    checkOutput("abort_addr", {26'd0, dp_address}, 0);
    checkOutput("abort_ready", {30'd0, req_ready}, 0);
    sawResp = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (resp_valid) sawResp++;
    end
    checkOutput("abort_noresp", sawResp, 0);
`ifdef HIER_STATS_EN
    checkOutput("stat_cleared", {16'd0, stat_miss}, 0);
`endif
    reset = 1'b1;
    applyStimulus("postrst", 2'b10, 0);
    waitResp("postrst", 7, 1'b1, 16'd3, 3, 0, 1);

`ifdef HIER_STATS_EN
    @(negedge clock);
    checkOutput("stat_final_l1", {16'd0, stat_l1_hit}, 0);
    checkOutput("stat_final_miss", {16'd0, stat_miss}, 1);
    checkOutput("stat_final_wb", {16'd0, stat_wb}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
